sort_net: RTL and testbench

Pipelined, parametrised sorting network. Each accepted vector of N unsigned or signed WIDTH-bit elements comes out fully sorted N cycles later, together with the original index of each output element. Sort direction is selected per vector. Valid/ready handshakes sit on both sides, so the block drops into streaming datapaths in place of fixed 4-input single-cycle comparators.

---
 rtl/sort_net_if.sv | 50 +++++
 rtl/sort_net.sv | 138 +++++++++++++
 tb/tb_sort_net.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_net_if.sv
// sort_net_if: valid/ready streaming bundle for sort_net.
// out_dup is present only when SORT_NET_DUP_EN is defined.
interface sort_net_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int IW = $clog2(N);

  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               in_desc;
  logic               out_valid;
  logic               out_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N*IW-1:0]    out_idx;
`ifdef SORT_NET_DUP_EN
  logic               out_dup;

  modport slave (
    input  in_valid, in_data, in_desc,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_idx,
    output out_dup
  );

  modport master (
    output in_valid, in_data, in_desc,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_idx,
    input  out_dup
  );
`else
  modport slave (
    input  in_valid, in_data, in_desc,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_idx
  );

  modport master (
    output in_valid, in_data, in_desc,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_idx
  );
`endif
endinterface

// File: rtl/sort_net.sv
// sort_net: elastic odd-even transposition sorter, N stages.
// Optional duplicate flag: define SORT_NET_DUP_EN.
module sort_net #(
  parameter int WIDTH  = 8,
  parameter int N      = 4,
  parameter int SIGNED = 0
) (
  input logic       clk,
  input logic       rst,
  sort_net_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef logic [N-1:0][WIDTH-1:0] vec_t;
  typedef logic [N-1:0][IW-1:0]    idx_t;

  vec_t         val_q [N];
  idx_t         idx_q [N];
  logic [N-2:0] desc_q;
  logic [N-1:0] vld_q;
  logic [N-1:0] rdy;

  vec_t         src_v [N];
  idx_t         src_x [N];
  logic [N-1:0] src_vld;
  logic [N-1:0] src_desc;
  vec_t         val_n [N];
  idx_t         idx_n [N];

`ifdef SORT_NET_DUP_EN
  logic [N-1:0] dup_q;
  logic [N-1:0] src_dup;
  logic [N-1:0] dup_n;

  assign src_dup = {dup_q[N-2:0], 1'b0};
`endif

  assign src_vld  = {vld_q[N-2:0], bus.in_valid};
  assign src_desc = {desc_q, bus.in_desc};

  function automatic logic less(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    if (SIGNED != 0)
      return $signed(a) < $signed(b);
    return a < b;
  endfunction

  // Stage k may load if any stage from k onward is empty or the sink drains
  always_comb begin
    for (int k = 0; k < N; k++) begin
      rdy[k] = bus.out_ready;
      for (int j = k; j < N; j++)
        if (!vld_q[j]) rdy[k] = 1'b1;
    end
  end

  assign bus.in_ready = rdy[0];

  // Compare-exchange layer for every stage, odd/even pairs alternating
  always_comb begin
    automatic vec_t v;
    automatic idx_t x;
    automatic logic sw;
`ifdef SORT_NET_DUP_EN
    automatic logic f;
`endif
    src_v[0] = bus.in_data;
    for (int i = 0; i < N; i++)
      src_x[0][i] = IW'(i);
    for (int k = 1; k < N; k++) begin
      src_v[k] = val_q[k-1];
      src_x[k] = idx_q[k-1];
    end
    for (int k = 0; k < N; k++) begin
      v = src_v[k];
      x = src_x[k];
      for (int i = 0; i < N - 1; i++) begin
        if ((i % 2) == (k % 2)) begin
          sw = src_desc[k] ? less(v[i], v[i+1])
                           : less(v[i+1], v[i]);
          if (sw) begin
            {v[i], v[i+1]} = {v[i+1], v[i]};
            {x[i], x[i+1]} = {x[i+1], x[i]};
          end
        end
      end
      val_n[k] = v;
      idx_n[k] = x;
`ifdef SORT_NET_DUP_EN
      f = src_dup[k];
      for (int i = 0; i < N - 1; i++)
        if (v[i] == v[i+1]) f = 1'b1;
      dup_n[k] = f;
`endif
    end
  end

  // Advance stages with room; bubbles clear valid but keep old payload
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      desc_q <= '0;
      for (int k = 0; k < N; k++) begin
        val_q[k] <= '0;
        idx_q[k] <= '0;
      end
`ifdef SORT_NET_DUP_EN
      dup_q <= '0;
`endif
    end else begin
      for (int k = 0; k < N; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= src_vld[k];
          if (src_vld[k]) begin
            val_q[k] <= val_n[k];
            idx_q[k] <= idx_n[k];
`ifdef SORT_NET_DUP_EN
            dup_q[k] <= dup_n[k];
`endif
          end
        end
      end
      for (int k = 0; k < N - 1; k++)
        if (rdy[k] && src_vld[k])
          desc_q[k] <= src_desc[k];
    end
  end

  assign bus.out_valid = vld_q[N-1];
  assign bus.out_data  = val_q[N-1];
  assign bus.out_idx   = idx_q[N-1];
`ifdef SORT_NET_DUP_EN
  assign bus.out_dup   = dup_q[N-1];
`endif

endmodule

// File: tb/tb_sort_net.sv
// tb_sort_net: directed + scoreboard bench for sort_net.
// Runs an unsigned and a signed instance side by side.
module tb_sort_net;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sort_net_if #(.WIDTH(W), .N(N)) bus ();
  sort_net_if #(.WIDTH(W), .N(N)) sbus ();

  assign sbus.in_valid  = bus.in_valid;
  assign sbus.in_data   = bus.in_data;
  assign sbus.in_desc   = bus.in_desc;
  assign sbus.out_ready = bus.out_ready;

  sort_net #(.WIDTH(W), .N(N), .SIGNED(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sort_net #(.WIDTH(W), .N(N), .SIGNED(1)) u_sdut (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  typedef struct packed {
    logic [N*W-1:0]  data;
    logic [N*IW-1:0] idx;
    logic            dup;
  } exp_t;

  exp_t qu[$];
  exp_t qs[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stable insertion sort reference
  function automatic exp_t model(
    input logic [N*W-1:0] din,
    input logic           desc,
    input bit             sgn
  );
    logic [W-1:0]  v [N];
    logic [IW-1:0] x [N];
    logic [W-1:0]  tv;
    logic [IW-1:0] tx;
    bit            mv;
    exp_t          e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = din[i*W +: W];
      x[i] = IW'(i);
    end
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (v[i] == v[j]) e.dup = 1'b1;
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0; j--) begin
        if (sgn)
          mv = desc ? ($signed(v[j-1]) < $signed(v[j]))
                    : ($signed(v[j-1]) > $signed(v[j]));
        else
          mv = desc ? (v[j-1] < v[j]) : (v[j-1] > v[j]);
        if (!mv) break;
        tv = v[j-1]; v[j-1] = v[j]; v[j] = tv;
        tx = x[j-1]; x[j-1] = x[j]; x[j] = tx;
      end
    end
    for (int j = 0; j < N; j++) begin
      e.data[j*W +: W]   = v[j];
      e.idx[j*IW +: IW]  = x[j];
    end
    return e;
  endfunction

  // Scoreboard: push on input transfer, pop on output transfer
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      qu.delete();
      qs.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        qu.push_back(model(bus.in_data, bus.in_desc, 1'b0));
        qs.push_back(model(bus.in_data, bus.in_desc, 1'b1));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("u_expected", 64'(qu.size() != 0), 64'd1);
        if (qu.size() != 0) begin
          e = qu.pop_front();
          check("u_data", 64'(bus.out_data), 64'(e.data));
          check("u_idx", 64'(bus.out_idx), 64'(e.idx));
`ifdef SORT_NET_DUP_EN
          check("u_dup", 64'(bus.out_dup), 64'(e.dup));
`endif
        end
      end
      if (sbus.out_valid && sbus.out_ready) begin
        check("s_expected", 64'(qs.size() != 0), 64'd1);
        if (qs.size() != 0) begin
          e = qs.pop_front();
          check("s_data", 64'(sbus.out_data), 64'(e.data));
          check("s_idx", 64'(sbus.out_idx), 64'(e.idx));
        end
      end
    end
  end

  task automatic send(input logic [N*W-1:0] d, input logic ds);
    int t;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_desc  = ds;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("send_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("out_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    int  guard;
    int  first;
    int  last;
    int  cnt;
    bit  acc;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_desc   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_idx", 64'(bus.out_idx), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_s_valid", 64'(sbus.out_valid), 64'd0);
`ifdef SORT_NET_DUP_EN
    check("rst_out_dup", 64'(bus.out_dup), 64'd0);
`endif
    rst           = 1'b0;
    bus.out_ready = 1'b1;

    send(32'h20401030, 1'b0);
    wait_out();
    check("asc_data", 64'(bus.out_data), 64'h40302010);
    check("asc_idx", 64'(bus.out_idx), 64'h8D);
    check("asc_s_data", 64'(sbus.out_data), 64'h40302010);

    send(32'h01050705, 1'b1);
    wait_out();
    check("desc_data", 64'(bus.out_data), 64'h01050507);
    check("desc_idx", 64'(bus.out_idx), 64'hE1);
`ifdef SORT_NET_DUP_EN
    check("desc_dup", 64'(bus.out_dup), 64'd1);
`endif

    send(32'hFF00807F, 1'b0);
    wait_out();
    check("uns_data", 64'(bus.out_data), 64'hFF807F00);
    check("uns_idx", 64'(bus.out_idx), 64'hD2);
    check("sgn_data", 64'(sbus.out_data), 64'h7F00FF80);
    check("sgn_idx", 64'(sbus.out_idx), 64'h2D);

    // Backpressure: stall first, then random sink
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = $urandom;
    bus.in_desc   = 1'($urandom);
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      bus.in_data = $urandom;
      bus.in_desc = 1'($urandom);
    end
    check("stall_accepts", 64'(sent), 64'd4);
    check("stall_ready", 64'(bus.in_ready), 64'd0);
    guard = 0;
    while (sent < 10 && guard < 300) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        bus.in_data = $urandom;
        bus.in_desc = 1'($urandom);
      end
      if (sent == 10) bus.in_valid = 1'b0;
      guard++;
    end
    check("bp_sent", 64'(sent), 64'd10);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (qu.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp_drained", 64'(qu.size()), 64'd0);

    // Back-to-back throughput, desc alternating
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_desc   = 1'b0;
    bus.in_data   = $urandom;
    first = -1;
    last  = -1;
    cnt   = 0;
    for (int c = 0; c < 28; c++) begin
      @(posedge clk); #1;
      if (c < 19) begin
        bus.in_data = $urandom;
        bus.in_desc = ~bus.in_desc;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.out_valid) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
    end
    check("tp_first", 64'(first), 64'd3);
    check("tp_count", 64'(cnt), 64'd20);
    check("tp_span", 64'(last - first), 64'd19);

    // Reset with three vectors in flight
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_desc  = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data", 64'(bus.out_data), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid || sbus.out_valid) cnt++;
    end
    check("post_rst_quiet", 64'(cnt), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
